// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg
// Shared definitions for the HUB75 BCM scanner:
//   - state_e     : scanner FSM states
//   - HUB75_COLS  : default pixels per row-vector (shift length)
//   - PLANE_W     : width of the bit-plane index
// ---------------------------------------------------------------------------
package hub75_pkg;

    localparam int HUB75_COLS = 64;
    localparam int PLANE_W    = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SHIFT   = 3'd2,
        BLANK   = 3'd3,
        LATCH   = 3'd4,
        DISPLAY = 3'd5
    } state_e;

endpackage

// File: rtl/hub75_bcm_scanner_bcm_on_timer.sv
// ---------------------------------------------------------------------------
// bcm_on_timer
// Times one binary-weighted display window and drives the panel OE for it.
// The window is W = BASE_TICKS << plane cycles; OE is asserted (low) for the
// first on_len = (W * brightness) >> 8 cycles and released for the remainder.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load a new window; the window runs in the following W cycles
//   plane       : bit-plane index of the window
//   brightness  : global brightness, sampled on start
//   oe_n        : panel output enable, active low; 1 whenever idle
//   done        : high in the last cycle of the window
// ---------------------------------------------------------------------------
module bcm_on_timer
    import hub75_pkg::*;
#(
    parameter int BASE_TICKS = 16,
    parameter int PLANES     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PLANE_W-1:0] plane,
    input  logic [7:0]         brightness,
    output logic               oe_n,
    output logic               done
);

    localparam int W_MAX = BASE_TICKS << (PLANES - 1);
    localparam int CNT_W = $clog2(W_MAX + 1);

    // Full-width product before the shift so no brightness resolution is lost.
    function automatic logic [CNT_W-1:0] on_len_f(input logic [CNT_W-1:0] win,
                                                  input logic [7:0]       bright);
        logic [CNT_W+7:0] prod;
        prod = (CNT_W+8)'(win) * (CNT_W+8)'(bright);
        return CNT_W'(prod >> 8);
    endfunction

    logic [CNT_W-1:0] win_len;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] off_at_q, off_at_d;
    logic             active_q, active_d;

    assign win_len = CNT_W'(BASE_TICKS) << plane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            rem_q    <= '0;
            off_at_q <= '0;
        end else begin
            active_q <= active_d;
            rem_q    <= rem_d;
            off_at_q <= off_at_d;
        end
    end

    // rem_q counts W..1 across the window; OE is on while the remaining
    // count is above W - on_len, i.e. during the first on_len cycles.
    always_comb begin
        active_d = active_q;
        rem_d    = rem_q;
        off_at_d = off_at_q;
        if (start) begin
            active_d = 1'b1;
            rem_d    = win_len;
            off_at_d = win_len - on_len_f(win_len, brightness);
        end else if (active_q) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    assign done = active_q && (rem_q == CNT_W'(1));
    assign oe_n = !(active_q && (rem_q > off_at_q));

endmodule

// File: rtl/hub75_bcm_scanner.sv
// ---------------------------------------------------------------------------
// hub75_bcm_scanner
// Fetches one row/bit-plane of six colour vectors from the line memory,
// shifts them out to a HUB75 panel, latches them and lights the row for a
// binary-weighted window scaled by a global brightness byte.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : scan enable (current plane always completes)
//   brightness        : global brightness 0..255
//   rd_req/rd_row/rd_plane/rd_valid : fetch handshake with the memory side
//   R1,G1,B1,R2,G2,B2 : colour vectors, sampled on the rd_valid cycle only
//   r1,g1,b1,r2,g2,b2 : panel serial data
//   pclk, lat, oe_n, addr : panel shift clock, latch, output enable, row
//   frame_done        : one-cycle pulse after the last plane of the last row
// ---------------------------------------------------------------------------
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int COLS       = HUB75_COLS,
    parameter int ROW_BITS   = 4,
    parameter int PLANES     = 8,
    parameter int BASE_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [7:0]          brightness,
    output logic                rd_req,
    output logic [ROW_BITS-1:0] rd_row,
    output logic [2:0]          rd_plane,
    input  logic                rd_valid,
    input  logic [COLS-1:0]     R1,
    input  logic [COLS-1:0]     G1,
    input  logic [COLS-1:0]     B1,
    input  logic [COLS-1:0]     R2,
    input  logic [COLS-1:0]     G2,
    input  logic [COLS-1:0]     B2,
    output logic                r1,
    output logic                g1,
    output logic                b1,
    output logic                r2,
    output logic                g2,
    output logic                b2,
    output logic                pclk,
    output logic                lat,
    output logic                oe_n,
    output logic [ROW_BITS-1:0] addr,
    output logic                frame_done
);

    localparam int CW = $clog2(2 * COLS);

    state_e                  state_q, state_d;
    logic [CW-1:0]           col_q;
    logic [5:0][COLS-1:0]    sh_q;
    logic [ROW_BITS-1:0]     row_q;
    logic [PLANE_W-1:0]      plane_q;
    logic [ROW_BITS-1:0]     addr_q;
    logic                    fd_q;
    logic                    tmr_start, tmr_done, tmr_oe_n;
    logic                    capture, advance, last_plane;

    assign capture    = (state_q == REQ) && rd_valid;
    assign advance    = (state_q == DISPLAY) && tmr_done;
    assign last_plane = (plane_q == PLANE_W'(PLANES - 1));
    assign tmr_start  = (state_q == LATCH);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = REQ;
            REQ:     if (rd_valid) state_d = SHIFT;
            SHIFT:   if (col_q == CW'(2 * COLS - 1)) state_d = BLANK;
            BLANK:   state_d = LATCH;
            LATCH:   state_d = DISPLAY;
            DISPLAY: if (tmr_done) state_d = en ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: data is only presented while shifting, pclk high on odd
    // half-columns so each bit is set up a full cycle before its rising edge.
    always_comb begin
        rd_req = 1'b0;
        pclk   = 1'b0;
        lat    = 1'b0;
        {r1, g1, b1, r2, g2, b2} = '0;
        case (state_q)
            REQ:   rd_req = 1'b1;
            SHIFT: begin
                pclk = col_q[0];
                {r1, g1, b1, r2, g2, b2} = {sh_q[0][COLS-1], sh_q[1][COLS-1],
                                            sh_q[2][COLS-1], sh_q[3][COLS-1],
                                            sh_q[4][COLS-1], sh_q[5][COLS-1]};
            end
            LATCH: lat = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) col_q <= '0;
        else if (state_q == SHIFT) col_q <= col_q + CW'(1);
        else col_q <= '0;
    end

    // Shift registers advance after the pclk-high half of each column.
    always_ff @(posedge clk) begin
        if (capture) begin
            sh_q <= {B2, G2, R2, B1, G1, R1};
        end else if (state_q == SHIFT && col_q[0]) begin
            for (int i = 0; i < 6; i++) begin
                sh_q[i] <= {sh_q[i][COLS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            plane_q <= '0;
            addr_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            fd_q <= advance && last_plane && (row_q == {ROW_BITS{1'b1}});
            if (state_q == LATCH) begin
                addr_q <= row_q;
            end
            if (advance) begin
                if (last_plane) begin
                    plane_q <= '0;
                    row_q   <= row_q + ROW_BITS'(1);
                end else begin
                    plane_q <= plane_q + PLANE_W'(1);
                end
            end
        end
    end

    bcm_on_timer #(
        .BASE_TICKS (BASE_TICKS),
        .PLANES     (PLANES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (tmr_start),
        .plane      (plane_q),
        .brightness (brightness),
        .oe_n       (tmr_oe_n),
        .done       (tmr_done)
    );

    assign rd_row     = row_q;
    assign rd_plane   = plane_q;
    assign addr       = addr_q;
    assign frame_done = fd_q;
    assign oe_n       = tmr_oe_n;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
module tb_hub75_bcm_scanner;

    localparam int COLS     = 64;
    localparam int ROW_BITS = 4;
    localparam int PLANES   = 8;
    localparam int BASE     = 4;
    localparam int FETCHES  = PLANES << ROW_BITS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic [7:0]          brightness = 8'd0;
    logic                rd_valid = 1'b0;
    logic [COLS-1:0]     R1 = '0, G1 = '0, B1 = '0, R2 = '0, G2 = '0, B2 = '0;
    logic                rd_req;
    logic [ROW_BITS-1:0] rd_row;
    logic [2:0]          rd_plane;
    logic                r1, g1, b1, r2, g2, b2, pclk, lat, oe_n, frame_done;
    logic [ROW_BITS-1:0] addr;

    always #5 clk = ~clk;

    hub75_bcm_scanner #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TICKS(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .brightness(brightness),
        .rd_req(rd_req), .rd_row(rd_row), .rd_plane(rd_plane), .rd_valid(rd_valid),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .pclk(pclk), .lat(lat), .oe_n(oe_n), .addr(addr), .frame_done(frame_done)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- memory-side responder ----------------
    bit directed = 1'b1;

    task automatic scramble();
        R1 = {$urandom, $urandom}; G1 = {$urandom, $urandom}; B1 = {$urandom, $urandom};
        R2 = {$urandom, $urandom}; G2 = {$urandom, $urandom}; B2 = {$urandom, $urandom};
    endtask

    initial begin : responder
        int d;
        forever begin
            @(posedge clk); #1;
            if (rd_req === 1'b1) begin
                d = directed ? 3 : int'($urandom_range(0, 4));
                repeat (d) begin @(posedge clk); #1; end
                if (directed) begin
                    R1 = 64'h8000_0000_0000_0001;
                    G1 = '0; B1 = '0; R2 = '0; G2 = '0; B2 = '0;
                    directed = 1'b0;
                end else begin
                    scramble();
                end
                rd_valid = 1'b1;
                @(posedge clk); #1;
                rd_valid = 1'b0;
                scramble();
            end else if ($urandom_range(0, 15) == 0) begin
                // stray valid outside a request must be ignored
                scramble();
                rd_valid = 1'b1;
                @(posedge clk); #1;
                rd_valid = 1'b0;
            end
        end
    end

    // ---------------- reference model / monitor ----------------
    logic [COLS-1:0] cap [6];
    logic [COLS-1:0] got [6];
    int  on_log [FETCHES];
    int  idx, cur_row, cur_plane, rises, win_i, win_w, on_exp, low_cnt, bad_cnt;
    int  oe_viol, fd_seen;
    bit  prev_req, prev_pclk, in_win, fd_pend, addr_pend;
    logic exp_oe;

    always @(negedge clk) begin
        if (!rst_n) begin
            idx = 0; prev_req = 0; prev_pclk = 0; in_win = 0;
            fd_pend = 0; addr_pend = 0; rises = 0;
        end else begin
            if (frame_done || fd_pend) chk("frame_done", 64'(frame_done), 64'(fd_pend));
            if (frame_done) fd_seen++;
            fd_pend = 0;
            if (addr_pend) begin
                chk("addr", 64'(addr), 64'(cur_row));
                addr_pend = 0;
            end
            if (rd_req && !prev_req) begin
                cur_row   = (idx / PLANES) % (1 << ROW_BITS);
                cur_plane = idx % PLANES;
                chk("fetch_row", 64'(rd_row), 64'(cur_row));
                chk("fetch_plane", 64'(rd_plane), 64'(cur_plane));
                rises = 0;
            end
            if (rd_req && rd_valid) begin
                cap[0] = R1; cap[1] = G1; cap[2] = B1;
                cap[3] = R2; cap[4] = G2; cap[5] = B2;
            end
            if (pclk && !prev_pclk) begin
                if (rises < COLS) begin
                    got[0][COLS-1-rises] = r1; got[1][COLS-1-rises] = g1;
                    got[2][COLS-1-rises] = b1; got[3][COLS-1-rises] = r2;
                    got[4][COLS-1-rises] = g2; got[5][COLS-1-rises] = b2;
                end
                rises++;
            end
            if (lat) begin
                chk("pclk_rises", 64'(rises), 64'(COLS));
                for (int j = 0; j < 6; j++) chk("shift_data", 64'(got[j]), 64'(cap[j]));
                if (oe_n !== 1'b1) oe_viol++;
                win_w  = BASE << cur_plane;
                on_exp = (win_w * int'(brightness)) / 256;
                win_i = 0; low_cnt = 0; bad_cnt = 0;
                in_win = 1; addr_pend = 1; rises = 0;
            end else if (in_win) begin
                exp_oe = (win_i < on_exp) ? 1'b0 : 1'b1;
                if (oe_n !== exp_oe) bad_cnt++;
                if (oe_n === 1'b0) low_cnt++;
                win_i++;
                if (win_i == win_w) begin
                    chk("oe_on_len", 64'(low_cnt), 64'(on_exp));
                    chk("oe_shape", 64'(bad_cnt), 64'd0);
                    in_win = 0;
                    if (idx < FETCHES) on_log[idx] = low_cnt;
                    if (idx % FETCHES == FETCHES - 1) fd_pend = 1;
                    idx++;
                end
            end else if (oe_n !== 1'b1) begin
                oe_viol++;
            end
            prev_req  = rd_req;
            prev_pclk = pclk;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // idle with en low: panel dark, no activity
        repeat (100) begin
            @(negedge clk);
            chk("idle_outs", 64'({oe_n, lat, pclk, rd_req, frame_done, addr, rd_row, rd_plane}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {ROW_BITS{1'b0}}, {ROW_BITS{1'b0}}, 3'd0}));
        end

        @(posedge clk); #1;
        brightness = 8'd255;
        en = 1'b1;

        n = 0;
        while (rd_row != 4'd1 && n < 30000) begin @(posedge clk); #1; n++; end
        chk("wait_row1", 64'(n < 30000), 64'd1);
        brightness = 8'd128;

        n = 0;
        while (rd_row != 4'd2 && n < 30000) begin @(posedge clk); #1; n++; end
        chk("wait_row2", 64'(n < 30000), 64'd1);
        brightness = 8'd0;

        n = 0;
        while (!(rd_row == 4'd2 && rd_plane == 3'd5 && pclk) && n < 30000) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_r2p5_shift", 64'(n < 30000), 64'd1);
        en = 1'b0;

        n = 0;
        while (rd_plane != 3'd6 && n < 5000) begin @(posedge clk); #1; n++; end
        chk("drop_plane_done", 64'(n < 5000), 64'd1);
        repeat (40) begin
            @(negedge clk);
            chk("parked_idle", 64'({rd_req, oe_n, pclk}), 64'({1'b0, 1'b1, 1'b0}));
        end

        @(posedge clk); #1;
        en = 1'b1;
        n = 0;
        while (rd_req !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("resume_req", 64'(n < 100), 64'd1);
        chk("resume_row", 64'(rd_row), 64'd2);
        chk("resume_plane", 64'(rd_plane), 64'd6);

        // rest of the frame with brightness wandering
        n = 0;
        while (frame_done !== 1'b1 && n < 60000) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 99) == 0) brightness = 8'($urandom);
            n++;
        end
        chk("frame_wait", 64'(n < 60000), 64'd1);
        chk("frame_row_wrap", 64'(rd_row), 64'd0);

        // fixed on-times from the first frame (W=128 at plane 5, W=32 at plane 3)
        chk("on_b255_w128", 64'(on_log[5]), 64'd127);
        chk("on_b255_w32", 64'(on_log[3]), 64'd31);
        chk("on_b128_w128", 64'(on_log[8 + 5]), 64'd64);
        chk("on_b0_w128", 64'(on_log[16 + 5]), 64'd0);

        // asynchronous reset in the middle of a lit window
        brightness = 8'd255;
        n = 0;
        while (oe_n !== 1'b0 && n < 5000) begin @(posedge clk); #1; n++; end
        chk("wait_lit", 64'(n < 5000), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe", 64'(oe_n), 64'd1);
        chk("async_ctl", 64'({lat, pclk, rd_req, addr, rd_row, rd_plane}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (rd_req !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("post_rst_req", 64'(n < 100), 64'd1);
        chk("post_rst_fetch", 64'({rd_row, rd_plane}), 64'd0);
        repeat (300) @(posedge clk);

        chk("oe_outside_window", 64'(oe_viol), 64'd0);
        chk("frame_done_count", 64'(fd_seen), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
